// File: rtl/wvb_trig_pkg.sv
// Shared definitions for the waveform-buffer trigger scheduler: source codes,
// default widths and a small population-count helper used by the lost counter.
package wvb_trig_pkg;

    localparam int ADC_WIDTH_DEF  = 12;
    localparam int CNST_WIDTH_DEF = 12;
    localparam int LOST_WIDTH_DEF = 16;

    // Source codes carried on trig_src; also used as bit positions in the
    // request vector so priority logic and counting share one encoding.
    localparam logic [1:0] TRIG_SRC_SW     = 2'd0;
    localparam logic [1:0] TRIG_SRC_THRESH = 2'd1;
    localparam logic [1:0] TRIG_SRC_CNST   = 2'd2;
    localparam logic [1:0] TRIG_SRC_EXT    = 2'd3;

    // Number of simultaneous requests (0..4).
    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/cnst_trig_gen.sv
// Constant-rate trigger generator: one registered request every
// (i_cnst_config + 1) cycles while i_cnst_run is high.
module cnst_trig_gen #(
    parameter int P_CNST_WIDTH = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cnst_run,
    input  logic [P_CNST_WIDTH-1:0] i_cnst_config,
    output logic                    o_req
);

    logic [P_CNST_WIDTH-1:0] r_cnt;
    logic                    r_req;

    // Period counter; a low run level discards any partial period.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_req <= 1'b0;
        end else if (!i_cnst_run) begin
            r_cnt <= '0;
            r_req <= 1'b0;
        end else if (r_cnt == i_cnst_config) begin
            r_cnt <= '0;
            r_req <= 1'b1;
        end else begin
            r_cnt <= r_cnt + {{(P_CNST_WIDTH-1){1'b0}}, 1'b1};
            r_req <= 1'b0;
        end
    end

    assign o_req = r_req;

endmodule

// File: rtl/wvb_trig_sched.sv
// Trigger scheduler for one ADC channel: merges software, threshold,
// constant-rate and external requests into a single registered trig/trig_src
// pair, gated by pretrigger-buffer readiness, and counts dropped requests.
module wvb_trig_sched
    import wvb_trig_pkg::*;
#(
    parameter int P_ADC_WIDTH  = ADC_WIDTH_DEF,
    parameter int P_CNST_WIDTH = CNST_WIDTH_DEF,
    parameter int P_LOST_WIDTH = LOST_WIDTH_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_ADC_WIDTH-1:0]  i_adc_in,
    input  logic [P_ADC_WIDTH-1:0]  i_thresh,
    input  logic                    i_thresh_en,
    input  logic                    i_sw_trig,
    input  logic                    i_ext_trig_in,
    input  logic                    i_ext_en,
    input  logic                    i_cnst_run,
    input  logic [P_CNST_WIDTH-1:0] i_cnst_config,
    input  logic                    i_ptb_rdy,
    input  logic                    i_lost_clr,
    output logic                    o_trig,
    output logic [1:0]              o_trig_src,
    output logic [P_LOST_WIDTH-1:0] o_lost_cnt
);

    logic                    w_hit;
    logic                    w_cnst_req;
    logic [3:0]              w_req;
    logic                    w_any;
    logic [1:0]              w_win_src;
    logic [2:0]              w_req_n;
    logic [2:0]              w_lost_inc;
    logic [P_LOST_WIDTH:0]   w_lost_sum;
    logic [P_LOST_WIDTH-1:0] w_lost_nxt;

    logic                    r_hit_d;
    logic                    r_ext_s1;
    logic                    r_ext_s2;
    logic                    r_ext_s3;
    logic                    r_req_sw;
    logic                    r_req_thr;
    logic                    r_req_ext;
    logic                    r_trig;
    logic [1:0]              r_trig_src;
    logic [P_LOST_WIDTH-1:0] r_lost;

    assign w_hit = (i_adc_in >= i_thresh);

    cnst_trig_gen #(
        .P_CNST_WIDTH (P_CNST_WIDTH)
    ) u_cnst (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_cnst_run    (i_cnst_run),
        .i_cnst_config (i_cnst_config),
        .o_req         (w_cnst_req)
    );

    // Edge detection, external synchronizer and the registered request stage;
    // hit_d and the synchronizer track regardless of the enables.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hit_d   <= 1'b0;
            r_ext_s1  <= 1'b0;
            r_ext_s2  <= 1'b0;
            r_ext_s3  <= 1'b0;
            r_req_sw  <= 1'b0;
            r_req_thr <= 1'b0;
            r_req_ext <= 1'b0;
        end else begin
            r_hit_d   <= w_hit;
            r_ext_s1  <= i_ext_trig_in;
            r_ext_s2  <= r_ext_s1;
            r_ext_s3  <= r_ext_s2;
            r_req_sw  <= i_sw_trig;
            r_req_thr <= w_hit & ~r_hit_d & i_thresh_en;
            r_req_ext <= r_ext_s2 & ~r_ext_s3 & i_ext_en;
        end
    end

    // Fixed-priority arbitration (ext > sw > cnst > thresh) and loss accounting.
    always_comb begin
        w_req     = '0;
        w_req[TRIG_SRC_SW]     = r_req_sw;
        w_req[TRIG_SRC_THRESH] = r_req_thr;
        w_req[TRIG_SRC_CNST]   = w_cnst_req;
        w_req[TRIG_SRC_EXT]    = r_req_ext;
        w_any     = |w_req;
        w_req_n   = popcnt4(w_req);

        if (w_req[TRIG_SRC_EXT]) begin
            w_win_src = TRIG_SRC_EXT;
        end else if (w_req[TRIG_SRC_SW]) begin
            w_win_src = TRIG_SRC_SW;
        end else if (w_req[TRIG_SRC_CNST]) begin
            w_win_src = TRIG_SRC_CNST;
        end else begin
            w_win_src = TRIG_SRC_THRESH;
        end

        // When blocked every request is lost; otherwise all but the winner.
        if (i_ptb_rdy && w_any) begin
            w_lost_inc = w_req_n - 3'd1;
        end else begin
            w_lost_inc = w_req_n;
        end

        w_lost_sum = {1'b0, r_lost} + {{(P_LOST_WIDTH-2){1'b0}}, w_lost_inc};
        if (i_lost_clr) begin
            w_lost_nxt = {{(P_LOST_WIDTH-3){1'b0}}, w_lost_inc};
        end else if (w_lost_sum[P_LOST_WIDTH]) begin
            w_lost_nxt = '1;
        end else begin
            w_lost_nxt = w_lost_sum[P_LOST_WIDTH-1:0];
        end
    end

    // Registered trigger outputs and saturating lost counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_trig     <= 1'b0;
            r_trig_src <= TRIG_SRC_SW;
            r_lost     <= '0;
        end else begin
            r_trig <= i_ptb_rdy & w_any;
            if (i_ptb_rdy && w_any) begin
                r_trig_src <= w_win_src;
            end else begin
                r_trig_src <= r_trig_src;
            end
            r_lost <= w_lost_nxt;
        end
    end

    assign o_trig     = r_trig;
    assign o_trig_src = r_trig_src;
    assign o_lost_cnt = r_lost;

endmodule

// File: doc/wvb_trig_sched.md
# wvb_trig_sched

Trigger scheduler for one mDOM ADC channel. It sits between the channel's pretrigger buffer / ADC stream and `wvb_wr_ctrl`. It merges four trigger sources into the single `trig` / `trig_src` pair that `wvb_wr_ctrl` consumes:

- software
- threshold crossing
- constant-rate
- external

It applies a fixed priority, gates on pretrigger-buffer readiness, and counts requests that lose arbitration or are blocked.

## Interface

Parameters:

- `P_ADC_WIDTH`, 12, ADC sample width
- `P_CNST_WIDTH`, 12, constant-rate period config width
- `P_LOST_WIDTH`, 16, lost-trigger counter width

Ports:

- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `adc_in`  in  P_ADC_WIDTH  ADC sample, same stream as PTB input
- `thresh`  in  P_ADC_WIDTH  threshold, unsigned
- `thresh_en`  in  1  threshold source enable
- `sw_trig`  in  1  one-cycle software trigger pulse
- `ext_trig_in`  in  1  external trigger, asynchronous level
- `ext_en`  in  1  external source enable
- `cnst_run`  in  1  constant-rate generator run level
- `cnst_config`  in  P_CNST_WIDTH  constant-rate period minus one
- `ptb_rdy`  in  1  pretrigger buffer full; triggers allowed
- `lost_clr`  in  1  clear lost counter
- `trig`  out  1  trigger pulse to `wvb_wr_ctrl`
- `trig_src`  out  2  source of `trig`: 0 sw, 1 thresh, 2 cnst, 3 ext
- `lost_cnt`  out  P_LOST_WIDTH  saturating count of dropped requests

## Operation

- **Threshold request.**
  - `hit = (adc_in >= thresh)`, unsigned compare at full width.
  - A request is raised on the rising edge of `hit` while `thresh_en` is high.
  - `hit_d` is registered. If `thresh_en` is low, `hit_d` still tracks, so enabling while above threshold gives no request.
- **External request.**
  - 2-flop synchronizer, then rising-edge detect.
  - `ext_en` gates the edge, not the synchronizer.
- **Software request.** `sw_trig` high.
- **Constant-rate request.**
  - The counter clears while `cnst_run` is low.
  - While `cnst_run` is high, it increments each cycle.
  - When the counter equals `cnst_config`, a request is raised and the counter returns to 0.
  - Period is `cnst_config + 1` cycles; `cnst_config = 0` gives a request every cycle.
  - Dropping `cnst_run` mid-period discards the partial count.
- **Arbitration** (same cycle), priority ext > sw > cnst > thresh.
  - The winner drives `trig = 1` with its code on the next edge.
  - Every other simultaneous request increments `lost_cnt` by one each.
- **Blocking.** If `ptb_rdy` is low, no trigger is issued and every request that cycle increments `lost_cnt`.
- **No queuing.** Requests are single-cycle events, never held pending.
- **`lost_cnt`.**
  - Increments by 0–4 per cycle and saturates at all-ones.
  - `lost_clr` zeroes it. If `lost_clr` coincides with new losses, the result is the new loss count.

## Timing

- Reset values: `trig = 0`, `trig_src = 0`, `lost_cnt = 0`, synchronizer/edge regs 0, constant counter 0, `hit_d = 0`.
- The first cycle after reset release can produce a threshold request if `adc_in >= thresh`.
- Latency from the qualifying input edge to `trig`:
  - sw: 1 cycle
  - thresh: 1 cycle (sample at edge N, `trig` high after edge N+1)
  - ext: 3 cycles from the first edge that samples `ext_trig_in` high
- Constant-rate: `cnst_run` is first sampled high at edge N. The request occurs at edge N+`cnst_config`, and `trig` is high in the cycle after edge N+`cnst_config`+1.
- `trig` is always one-cycle-per-request and registered. Back-to-back `trig` on consecutive cycles is legal; `wvb_wr_ctrl` handles retriggers.
- `rst` mid-operation: all state returns to reset values on the next edge, and any in-flight request is lost without being counted.

## Structure

- Shared package `wvb_trig_pkg`:
  - source codes `TRIG_SRC_SW = 2'd0`, `TRIG_SRC_THRESH = 2'd1`, `TRIG_SRC_CNST = 2'd2`, `TRIG_SRC_EXT = 2'd3`
  - default widths
- Sub-module `cnst_trig_gen` contains the constant-rate counter: inputs `cnst_run`, `cnst_config`; output request pulse.
- Arbitration, edge detection, synchronizer and lost counter live in the top.

## Test plan

- **Threshold crossing.** `thresh = 100`, `adc_in` ramps by 1 from 0.
  - Expect `trig = 1`, `trig_src = 1` exactly once, 1 cycle after `adc_in` = 100.
  - Holding above threshold produces no further `trig`.
- **Constant-rate.** `cnst_config = 10`, `cnst_run` high at cycle 178.
  - Expect `trig_src = 2` at cycles 189, 200, 211, …
  - Dropping `cnst_run` at 205 gives no `trig` at 211.
- **Collision.** `sw_trig` pulse, ext edge and threshold crossing all aligned to the same arbitration cycle.
  - Expect one `trig` with `trig_src = 3`.
  - Expect `lost_cnt` to go 0 → 2.
- **Blocking.** `ptb_rdy = 0`, `sw_trig` pulsed 3 times.
  - Expect no `trig` and `lost_cnt = 3`.
  - `lost_clr` then gives `lost_cnt = 0`.
- **Saturation.** `P_LOST_WIDTH = 4`, 20 blocked sw pulses.
  - Expect `lost_cnt = 15` and held.
- **Reset mid-period.** `cnst_config = 10`, assert `rst` 5 cycles after `cnst_run`.
  - Expect all outputs 0.
  - After release with `cnst_run` still high, the next `trig` comes 11 cycles after the first edge that samples `rst` low.
